wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order writeback stream leaving the MEM/WB pipeline register and a long-latency execution unit (M-extension divider, F-unit) that completes out of band. The pipeline has priority. A one-entry holding buffer absorbs a colliding long-unit result, and a starvation counter briefly freezes MEM/WB so the buffer can drain. The block sits between the MEM/WB register outputs, the long-unit result interface and the regfile write port, and reports the pending destination to the hazard unit.

## Interface
- DATA_WIDTH, 32, width of write data
- STARVE_LIMIT, 4, cycles a buffered result may wait before a forced drain (range 1..255)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- RegWriteW  in  1  pipeline WB write enable (from MEM/WB)
- RdW  in  5  pipeline WB destination
- ResultW  in  DATA_WIDTH  pipeline WB data (post ResultSrc mux)
- lu_valid  in  1  long-unit result valid
- lu_rd  in  5  long-unit destination
- lu_data  in  DATA_WIDTH  long-unit result
- lu_ready  out  1  arbiter accepts lu result this cycle
- rf_we  out  1  regfile write enable
- rf_rd  out  5  regfile write address
- rf_wd  out  DATA_WIDTH  regfile write data
- wb_stall  out  1  hold MEM/WB contents this cycle (enable low)
- pend_valid  out  1  buffer holds an unwritten result
- pend_rd  out  5  destination of buffered result

## Operation
- Pipeline slot is "busy" when RegWriteW=1, RdW!=0 and wb_stall=0. Otherwise the slot is "free".
- Write-port select, combinational, highest priority first:
  - wb_stall=1: write the buffer.
  - slot busy: write the pipeline.
  - pend_valid=1: write the buffer.
  - lu handshake with rd!=0: write lu directly (bypass).
  - otherwise: rf_we=0.
- Writes to x0 never assert rf_we. An lu result with lu_rd=0 is accepted and discarded.
- lu_ready = ~pend_valid | buffer draining this cycle. The handshake is lu_valid & lu_ready.
- Buffer capture: handshake occurs while the slot is busy, or while the buffer drains. The new result is loaded at the clock edge.
- WAW kill: slot busy with RdW==pend_rd while pend_valid=1 clears the buffer without writing it. The pipeline value is newer. The kill also applies to a result being captured in the same cycle with RdW==lu_rd; that result is discarded.
- States:
  - EMPTY (pend_valid=0).
  - HELD (pend_valid=1, count increments each cycle not drained).
  - FORCE (wb_stall=1 for exactly one cycle).
- Transitions:
  - EMPTY to HELD on capture.
  - HELD to EMPTY on drain or kill.
  - HELD to FORCE when count reaches STARVE_LIMIT at a clock edge.
  - FORCE to EMPTY, or to HELD if a new result is captured in the same cycle (count reset to 0).
- Count width is 8 bits and saturates. It resets to 0 on every capture.
- During wb_stall the pipeline instruction is held, not lost. It writes in the following cycle.

## Timing
- Bypass write: 0 cycles from lu handshake (same cycle as lu_valid).
- Buffered write: at least 1 cycle after capture, at most STARVE_LIMIT+1 cycles.
- wb_stall is registered. It is asserted for one cycle starting at the edge where the HELD count reaches STARVE_LIMIT.
- rf_we/rf_rd/rf_wd are combinational. The regfile samples them at the next rising edge.
- Reset (rst_n=0, asynchronous):
  - pend_valid=0, pend_rd=0, buffer data=0, count=0, state EMPTY.
  - wb_stall=0, rf_we forced 0, lu_ready=1.
  - Reset mid-HELD drops the buffered result.
- Simultaneous drain and capture: the old entry is written and the new entry is loaded at the same edge, with no bubble.

## Test plan
- Idle slot, lu_valid=1, lu_rd=5, lu_data=0xA5A5A5A5 -> same cycle rf_we=1, rf_rd=5, rf_wd=0xA5A5A5A5; pend_valid stays 0.
- Pipeline writes x3 while lu delivers x7=0x11 -> cycle 0 rf_rd=3; pend_valid=1, pend_rd=7. Next cycle, with the slot free, rf_rd=7, rf_wd=0x11, then pend_valid=0.
- Buffered x7 with STARVE_LIMIT=4 and the pipeline busy every cycle -> after 4 busy cycles wb_stall=1 for exactly one cycle, rf_rd=7. The held pipeline write lands the next cycle with its data intact.
- Buffered x9, then the pipeline writes x9=0x22 -> rf_wd=0x22, buffer cleared, and x9 is never written with the stale lu value.
- lu_rd=0 with lu_valid=1 and pipeline writes to x0 -> rf_we=0 throughout, and lu_ready=1 on every cycle.
- Assert rst_n=0 while in HELD -> pend_valid=0, wb_stall=0, rf_we=0, lu_ready=1 immediately, with no write after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the MEM/WB stream (priority) and an out-of-band long unit.
// Latency: lu bypass is same-cycle; a buffered result drains within STARVE_LIMIT+1 cycles.
// Backpressure: lu_ready drops while the buffer is occupied and not draining; wb_stall freezes MEM/WB.
module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteW,
    input  logic [4:0]            RdW,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  lu_valid,
    input  logic [4:0]            lu_rd,
    input  logic [DATA_WIDTH-1:0] lu_data,
    output logic                  lu_ready,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wd,
    output logic                  wb_stall,
    output logic                  pend_valid,
    output logic [4:0]            pend_rd
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } state_e;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [4:0]            pend_rd_q, pend_rd_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            cnt_inc;

    logic slot_busy;
    logic drain;
    logic kill;
    logic hs;
    logic capture;

    assign wb_stall   = (state_q == ST_FORCE);
    assign pend_valid = (state_q != ST_EMPTY);
    assign pend_rd    = pend_rd_q;

    assign slot_busy = RegWriteW && (RdW != 5'd0) && !wb_stall;
    // The buffer is written whenever the pipeline does not own the port.
    assign drain     = pend_valid && (wb_stall || !slot_busy);
    assign kill      = slot_busy && pend_valid && (RdW == pend_rd_q);
    assign lu_ready  = !pend_valid || drain;
    assign hs        = lu_valid && lu_ready;
    // A same-cycle pipeline write to the same register supersedes the lu result.
    assign capture   = hs && (lu_rd != 5'd0) && (slot_busy || drain)
                       && !(slot_busy && (RdW == lu_rd));
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        rf_we = 1'b0;
        rf_rd = 5'd0;
        rf_wd = '0;
        if (wb_stall) begin
            rf_we = 1'b1;
            rf_rd = pend_rd_q;
            rf_wd = pend_data_q;
        end else if (slot_busy) begin
            rf_we = 1'b1;
            rf_rd = RdW;
            rf_wd = ResultW;
        end else if (pend_valid) begin
            rf_we = 1'b1;
            rf_rd = pend_rd_q;
            rf_wd = pend_data_q;
        end else if (hs && (lu_rd != 5'd0)) begin
            rf_we = 1'b1;
            rf_rd = lu_rd;
            rf_wd = lu_data;
        end
        if (!rst_n) begin
            rf_we = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        pend_data_d = pend_data_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (capture) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (drain) begin
                    state_d = capture ? ST_HELD : ST_EMPTY;
                end else if (kill) begin
                    state_d = ST_EMPTY;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= LIMIT) state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                state_d = capture ? ST_HELD : ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (capture) begin
            pend_rd_d   = lu_rd;
            pend_data_d = lu_data;
            cnt_d       = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            pend_rd_q   <= 5'd0;
            pend_data_q <= '0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_data_q <= pend_data_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready, rf_we, wb_stall, pend_valid;
    logic [4:0]  rf_rd, pend_rd;
    logic [31:0] rf_wd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .wb_stall(wb_stall), .pend_valid(pend_valid), .pend_rd(pend_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        RegWriteW = we; RdW = rd; ResultW = res;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_pend_valid", 32'(pend_valid), 0);
        chk("rst_wb_stall", 32'(wb_stall), 0);
        chk("rst_lu_ready", 32'(lu_ready), 1);
        chk("rst_rf_we", 32'(rf_we), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Bypass into an idle slot
        drive(0, 0, 0, 1, 5, 32'hA5A5A5A5);
        chk("byp_we", 32'(rf_we), 1);
        chk("byp_rd", 32'(rf_rd), 5);
        chk("byp_wd", rf_wd, 32'hA5A5A5A5);
        chk("byp_ready", 32'(lu_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("byp_no_pend", 32'(pend_valid), 0);
        chk("byp_idle_we", 32'(rf_we), 0);

        // Collision then drain on a free slot
        drive(1, 3, 32'h33, 1, 7, 32'h11);
        chk("col_rd", 32'(rf_rd), 3);
        chk("col_wd", rf_wd, 32'h33);
        chk("col_ready", 32'(lu_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("col_pend_valid", 32'(pend_valid), 1);
        chk("col_pend_rd", 32'(pend_rd), 7);
        chk("col_drain_we", 32'(rf_we), 1);
        chk("col_drain_rd", 32'(rf_rd), 7);
        chk("col_drain_wd", rf_wd, 32'h11);
        tick();
        chk("col_empty", 32'(pend_valid), 0);
        chk("col_after_we", 32'(rf_we), 0);

        // Starvation: pipeline busy every cycle
        drive(1, 3, 32'h33, 1, 7, 32'h77);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(10 + i), 32'(i), 1, 8, 32'h88);
            chk("stv_rd", 32'(rf_rd), 32'(10 + i));
            chk("stv_stall", 32'(wb_stall), 0);
            chk("stv_ready", 32'(lu_ready), 0);
            tick();
        end
        drive(1, 15, 32'h15, 0, 0, 0);
        chk("stv_force_stall", 32'(wb_stall), 1);
        chk("stv_force_rd", 32'(rf_rd), 7);
        chk("stv_force_wd", rf_wd, 32'h77);
        tick();
        chk("stv_release_stall", 32'(wb_stall), 0);
        chk("stv_held_rd", 32'(rf_rd), 15);
        chk("stv_held_wd", rf_wd, 32'h15);
        chk("stv_empty", 32'(pend_valid), 0);
        tick();

        // WAW kill
        drive(1, 3, 32'h33, 1, 9, 32'h99);
        tick();
        drive(1, 9, 32'h22, 0, 0, 0);
        chk("waw_rd", 32'(rf_rd), 9);
        chk("waw_wd", rf_wd, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("waw_cleared", 32'(pend_valid), 0);
        chk("waw_no_stale", 32'(rf_we), 0);
        tick();

        // x0 writes from both sources
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
            chk("x0_we", 32'(rf_we), 0);
            chk("x0_ready", 32'(lu_ready), 1);
            chk("x0_pend", 32'(pend_valid), 0);
            tick();
        end

        // Simultaneous drain and capture
        drive(1, 3, 32'h33, 1, 7, 32'h71);
        tick();
        drive(0, 0, 0, 1, 8, 32'h81);
        chk("dc_rd", 32'(rf_rd), 7);
        chk("dc_wd", rf_wd, 32'h71);
        chk("dc_ready", 32'(lu_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("dc_pend_valid", 32'(pend_valid), 1);
        chk("dc_pend_rd", 32'(pend_rd), 8);
        chk("dc_wd2", rf_wd, 32'h81);
        tick();
        chk("dc_empty", 32'(pend_valid), 0);

        // Reset while HELD
        drive(1, 3, 32'h33, 1, 7, 32'h55);
        tick();
        drive(1, 4, 32'h44, 0, 0, 0);
        chk("rh_held", 32'(pend_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rh_pend_valid", 32'(pend_valid), 0);
        chk("rh_stall", 32'(wb_stall), 0);
        chk("rh_we", 32'(rf_we), 0);
        chk("rh_ready", 32'(lu_ready), 1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rh_post_we", 32'(rf_we), 0);
        tick();
        chk("rh_post_we2", 32'(rf_we), 0);
        chk("rh_post_pend", 32'(pend_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
